// File: rtl/sdram_rfifo.sv
// Read-data buffer downstream of the SDRAM read engine: a circular FIFO with
// registered read data, occupancy reporting and sticky overflow/underflow flags.
module sdram_rfifo #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int AW        = 4,
    parameter int BURST_LEN = 4
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic              clr_err,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic [AW:0]       count,
    output logic              space_ok,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [AW:0] DEPTH_C     = (AW+1)'(DEPTH);
    localparam logic [AW:0] SPACE_LIMIT = (AW+1)'(DEPTH - BURST_LEN);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wp;
    logic [AW-1:0]     rp;
    logic              wa;
    logic              ra;

    assign full     = (count == DEPTH_C);
    assign empty    = (count == '0);
    assign space_ok = (count <= SPACE_LIMIT);

    // Accepts use the registered count, so a same-cycle read never frees room
    // for a write and a same-cycle write is never readable (no fall-through).
    assign wa = wr_en & ~full;
    assign ra = rd_en & ~empty;

    // Storage carries no reset; contents are meaningless until written.
    always_ff @(posedge sys_clk) begin
        if (wa) begin
            mem[wp] <= wr_data;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wp        <= '0;
            rp        <= '0;
            count     <= '0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            rd_valid <= ra;
            if (wa) begin
                wp <= wp + 1'b1;
            end
            if (ra) begin
                rd_data <= mem[rp];
                rp      <= rp + 1'b1;
            end
            if (wa && !ra) begin
                count <= count + 1'b1;
            end else if (ra && !wa) begin
                count <= count - 1'b1;
            end
            // Set dominates a coincident clear.
            overflow  <= (wr_en & full)  | (overflow  & ~clr_err);
            underflow <= (rd_en & empty) | (underflow & ~clr_err);
        end
    end

endmodule
